// File: rtl/sdram_sim_mc.sv
// sdram_sim_mc: multi-channel behavioural SDRAM model.
// One serialised word array behind req/ack arbitration and refresh stalls.
module sdram_sim_mc #(
  parameter int    NCH        = 3,
  parameter int    DW         = 16,
  parameter int    AW         = 22,
  parameter int    DEPTH_LOG2 = 22,
  parameter int    ACC_CYC    = 4,
  parameter int    REF_INT    = 0,
  parameter int    REF_CYC    = 6,
  parameter bit    RR         = 1'b1,
  parameter string INIT_FILE  = ""
) (
  input  logic                  clkref,
  input  logic                  reset,
  input  logic [NCH-1:0]        req,
  input  logic [NCH-1:0]        we,
  input  logic [NCH*AW-1:0]     addr,
  input  logic [NCH*DW-1:0]     din,
  input  logic [NCH*DW/8-1:0]   be,
  output logic [NCH-1:0]        ack,
  output logic [NCH*DW-1:0]     dout,
  output logic [NCH-1:0]        dvalid,
  output logic                  busy
);
  localparam int BW   = DW / 8;
  localparam int PW   = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int CMAX = (ACC_CYC > REF_CYC) ? ACC_CYC : REF_CYC;
  localparam int CW   = $clog2(CMAX + 1);
  localparam int RI   = (REF_INT > 1) ? REF_INT : 2;
  localparam int RW   = $clog2(RI);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ACC  = 2'd1;
  localparam logic [1:0] S_REF  = 2'd2;

  logic [DW-1:0]         mem [2**DEPTH_LOG2];
  logic [1:0]            state;
  logic [CW-1:0]         cnt;
  logic [RW-1:0]         ref_cnt;
  logic                  ref_pend;
  logic                  ref_wrap;
  logic [PW-1:0]         rr_ptr;
  logic [PW-1:0]         gnt_idx;
  logic [PW-1:0]         ix;
  logic [PW-1:0]         cur_ch;
  logic                  gnt_any;
  logic                  cur_rd;
  logic                  start;
  logic [DW-1:0]         rd_word;
  logic [DEPTH_LOG2-1:0] g_row;
  logic [DW-1:0]         g_din;
  logic [BW-1:0]         g_be;

  // Walk the candidates from lowest to highest priority so the last hit wins.
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    ix      = '0;
    for (int i = NCH; i >= 1; i--) begin
      ix = RR ? PW'((int'(rr_ptr) + i) % NCH) : PW'(i - 1);
      if (req[ix]) begin
        gnt_any = 1'b1;
        gnt_idx = ix;
      end
    end
  end

  assign g_row    = addr[int'(gnt_idx)*AW +: DEPTH_LOG2];
  assign g_din    = din[int'(gnt_idx)*DW +: DW];
  assign g_be     = be[int'(gnt_idx)*BW +: BW];
  assign start    = !reset && (state == S_IDLE) && !ref_pend && gnt_any;
  assign ref_wrap = (REF_INT > 0) && (ref_cnt == RW'(REF_INT - 1));
  assign busy     = (state != S_IDLE) || ref_pend;

  always_ff @(posedge clkref) begin
    if (start && we[gnt_idx]) begin
      for (int b = 0; b < BW; b++) begin
        if (g_be[b]) mem[g_row][b*8 +: 8] <= g_din[b*8 +: 8];
      end
    end
    if (start) rd_word <= mem[g_row];
  end

  always_ff @(posedge clkref) begin
    if (reset) begin
      state    <= S_IDLE;
      cnt      <= '0;
      ref_cnt  <= '0;
      ref_pend <= 1'b0;
      rr_ptr   <= PW'(NCH - 1);
      cur_ch   <= '0;
      cur_rd   <= 1'b0;
      ack      <= '0;
      dvalid   <= '0;
      dout     <= '0;
    end else begin
      ack    <= '0;
      dvalid <= '0;
      if (REF_INT > 0) ref_cnt <= ref_wrap ? '0 : ref_cnt + 1'b1;
      if (ref_wrap) ref_pend <= 1'b1;
      unique case (state)
        S_IDLE: begin
          cnt <= '0;
          if (ref_pend) begin
            state    <= S_REF;
            ref_pend <= 1'b0;
          end else if (gnt_any) begin
            state        <= S_ACC;
            ack[gnt_idx] <= 1'b1;
            cur_ch       <= gnt_idx;
            cur_rd       <= !we[gnt_idx];
            if (RR) rr_ptr <= gnt_idx;
          end
        end
        S_ACC: begin
          cnt <= cnt + 1'b1;
          if (cnt == CW'(ACC_CYC - 2)) begin
            state <= S_IDLE;
            if (cur_rd) begin
              dout[int'(cur_ch)*DW +: DW] <= rd_word;
              dvalid[cur_ch]              <= 1'b1;
            end
          end
        end
        S_REF: begin
          cnt <= cnt + 1'b1;
          if (cnt == CW'(REF_CYC - 1)) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_sdram_sim_mc.sv
// tb_sdram_sim_mc: two model instances (round-robin / fixed+refresh)
// checked cycle by cycle against a transaction-level reference.
module tb_sdram_sim_mc;
  localparam int ACC = 4;
  localparam int REFI = 20;
  localparam int REFC = 6;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [2:0]  req [2];
  logic [2:0]  we [2];
  logic [65:0] addr [2];
  logic [47:0] din [2];
  logic [5:0]  be [2];
  logic [2:0]  ack [2];
  logic [47:0] dout [2];
  logic [2:0]  dvalid [2];
  logic        busy [2];

  for (genvar g = 0; g < 2; g++) begin : g_dut
    sdram_sim_mc #(
      .NCH(3), .DW(16), .AW(22), .DEPTH_LOG2(10),
      .ACC_CYC(ACC), .REF_INT(g == 0 ? 0 : REFI),
      .REF_CYC(REFC), .RR(g == 0)
    ) u_dut (
      .clkref(clk), .reset(rst),
      .req(req[g]), .we(we[g]), .addr(addr[g]),
      .din(din[g]), .be(be[g]), .ack(ack[g]),
      .dout(dout[g]), .dvalid(dvalid[g]),
      .busy(busy[g])
    );
  end

  int nvec = 0;
  int nmis = 0;
  int cyc = 0;

  logic [15:0] mm [2][1024];
  bit [1:0]    mk [2][1024];
  int          free_at [2];
  int          ref_org [2];
  int          ptr [2];
  bit          pend [2];
  bit          e_busy [2];
  logic [2:0]  e_ack [2];
  logic [2:0]  e_dv [2];
  logic [15:0] e_do [2][3];
  logic [15:0] e_dm [2][3];
  bit          rd_on [2];
  int          rd_due [2];
  int          rd_ch [2];
  logic [15:0] rd_dat [2];
  logic [15:0] rd_msk [2];
  int          q_ch0[$];
  int          q_ch1[$];
  int          q_t[$];

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    nvec++;
    if (obs !== exp) begin
      nmis++;
      $display("FAIL %s: got %0h want %0h at cycle %0d",
               tag, obs, exp, cyc);
    end
  endtask

  function automatic logic [15:0] bmask(input bit [1:0] b);
    return {{8{b[1]}}, {8{b[0]}}};
  endfunction

  function automatic int pick(input int g, input logic [2:0] r);
    for (int i = 1; i <= 3; i++) begin
      int k = (g == 0) ? (ptr[g] + i) % 3 : i - 1;
      if (r[k]) return k;
    end
    return -1;
  endfunction

  task automatic step(input int g);
    int k;
    int a;
    bit to_ref;
    e_ack[g] = '0;
    e_dv[g] = '0;
    to_ref = 1'b0;
    if (rst) begin
      free_at[g] = cyc + 1;
      ref_org[g] = cyc;
      pend[g] = 1'b0;
      ptr[g] = 2;
      rd_on[g] = 1'b0;
      e_busy[g] = 1'b0;
      for (int c = 0; c < 3; c++) begin
        e_do[g][c] = '0;
        e_dm[g][c] = 16'hFFFF;
      end
      return;
    end
    if (rd_on[g] && rd_due[g] == cyc) begin
      e_dv[g][rd_ch[g]] = 1'b1;
      e_do[g][rd_ch[g]] = rd_dat[g];
      e_dm[g][rd_ch[g]] = rd_msk[g];
      rd_on[g] = 1'b0;
    end
    if (cyc >= free_at[g]) begin
      if (pend[g]) begin
        pend[g] = 1'b0;
        to_ref = 1'b1;
        free_at[g] = cyc + REFC + 1;
      end else if (req[g] != 0) begin
        k = pick(g, req[g]);
        e_ack[g][k] = 1'b1;
        ptr[g] = k;
        free_at[g] = cyc + ACC;
        a = int'(addr[g][k*22 +: 10]);
        if (we[g][k]) begin
          for (int b = 0; b < 2; b++) begin
            if (be[g][k*2+b]) begin
              mm[g][a][b*8 +: 8] = din[g][k*16+b*8 +: 8];
              mk[g][a][b] = 1'b1;
            end
          end
        end else begin
          rd_on[g] = 1'b1;
          rd_due[g] = cyc + ACC - 1;
          rd_ch[g] = k;
          rd_dat[g] = mm[g][a];
          rd_msk[g] = bmask(mk[g][a]);
        end
      end
    end
    if (g == 1 && cyc > ref_org[g] && (cyc - ref_org[g]) % REFI == 0
        && !to_ref)
      pend[g] = 1'b1;
    e_busy[g] = (cyc < free_at[g] - 1) || pend[g];
  endtask

  task automatic cmp(input int g);
    chk($sformatf("ack%0d", g), ack[g], e_ack[g]);
    chk($sformatf("dvalid%0d", g), dvalid[g], e_dv[g]);
    chk($sformatf("busy%0d", g), busy[g], e_busy[g]);
    for (int c = 0; c < 3; c++)
      chk($sformatf("dout%0d_%0d", g, c),
          dout[g][c*16 +: 16] & e_dm[g][c], e_do[g][c] & e_dm[g][c]);
  endtask

  task automatic cycle();
    @(posedge clk);
    step(0);
    step(1);
    @(negedge clk);
    cmp(0);
    cmp(1);
    cyc++;
  endtask

  task automatic xfer(input int g, input int c, input bit w,
                      input logic [21:0] a, input logic [15:0] d,
                      input logic [1:0] b, output int lat);
    int t0 = cyc;
    bit got = 1'b0;
    req[g][c] = 1'b1;
    we[g][c] = w;
    addr[g][c*22 +: 22] = a;
    din[g][c*16 +: 16] = d;
    be[g][c*2 +: 2] = b;
    for (int i = 0; i < 100 && !got; i++) begin
      cycle();
      got = ack[g][c];
    end
    req[g][c] = 1'b0;
    chk("ack_seen", ack[g][c], 1);
    lat = cyc - t0;
  endtask

  task automatic wait_dv(input int g, input int c, output int t);
    bit got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      cycle();
      got = dvalid[g][c];
    end
    chk("dvalid_seen", dvalid[g][c], 1);
    t = cyc;
  endtask

  task automatic new_req(input int g, input int c);
    req[g][c] = 1'b1;
    we[g][c] = 1'($urandom_range(0, 1));
    addr[g][c*22 +: 22] = {12'($urandom), 6'd0, 4'($urandom)};
    din[g][c*16 +: 16] = 16'($urandom);
    be[g][c*2 +: 2] = 2'($urandom);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int lat;
    int ta;
    int td;
    int ndv;
    int bad;
    int n11;
    for (int g = 0; g < 2; g++) begin
      req[g] = '0; we[g] = '0; addr[g] = '0;
      din[g] = '0; be[g] = '0;
    end
    rst = 1'b1;
    repeat (3) cycle();
    rst = 1'b0;

    xfer(0, 0, 1'b1, 22'h10, 16'hBEEF, 2'b11, lat);
    chk("wr_ack_lat", lat, 1);
    xfer(0, 0, 1'b0, 22'h10, 16'h0, 2'b00, lat);
    ta = cyc;
    wait_dv(0, 0, td);
    chk("rd_dv_lat", td - ta, ACC - 1);
    chk("rd_beef", dout[0][15:0], 16'hBEEF);

    xfer(0, 0, 1'b1, 22'h20, 16'h1234, 2'b11, lat);
    xfer(0, 0, 1'b1, 22'h20, 16'hAB00, 2'b10, lat);
    xfer(0, 0, 1'b1, 22'h20, 16'h00CD, 2'b01, lat);
    xfer(0, 0, 1'b0, 22'h20, 16'h0, 2'b00, lat);
    wait_dv(0, 0, td);
    chk("be_merge", dout[0][15:0], 16'hABCD);
    xfer(0, 0, 1'b1, 22'h20, 16'hFFFF, 2'b00, lat);
    xfer(0, 0, 1'b0, 22'h20, 16'h0, 2'b00, lat);
    wait_dv(0, 0, td);
    chk("be_none", dout[0][15:0], 16'hABCD);

    rst = 1'b1;
    cycle();
    rst = 1'b0;
    for (int g = 0; g < 2; g++) begin
      req[g] = 3'b111;
      we[g] = 3'b000;
      addr[g] = {22'h30, 22'h20, 22'h10};
    end
    for (int i = 0; i < 40; i++) begin
      cycle();
      for (int c = 0; c < 3; c++) begin
        if (ack[0][c]) begin
          q_ch0.push_back(c);
          q_t.push_back(cyc);
        end
        if (ack[1][c]) q_ch1.push_back(c);
      end
    end
    req[0] = '0;
    req[1] = '0;
    chk("rr_count", q_ch0.size(), 10);
    for (int i = 0; i < 6; i++) chk("rr_order", q_ch0[i], i % 3);
    for (int i = 1; i < q_t.size(); i++)
      chk("rr_gap", q_t[i] - q_t[i-1], ACC);
    chk("fp_any", q_ch1.size() > 0, 1);
    foreach (q_ch1[i]) chk("fp_ch0", q_ch1[i], 0);

    repeat (12) cycle();
    q_t.delete();
    new_req(1, 1);
    for (int i = 0; i < 150; i++) begin
      cycle();
      if (ack[1][1]) begin
        q_t.push_back(cyc);
        new_req(1, 1);
      end
    end
    req[1] = '0;
    bad = 0;
    n11 = 0;
    for (int i = 1; i < q_t.size(); i++) begin
      if (q_t[i] - q_t[i-1] == ACC + REFC + 1) n11++;
      else if (q_t[i] - q_t[i-1] != ACC) bad++;
    end
    chk("ref_gap_bad", bad, 0);
    chk("ref_stalls", n11 >= 5, 1);

    repeat (10) cycle();
    xfer(0, 2, 1'b0, 22'h10, 16'h0, 2'b00, lat);
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    chk("rst_ack", ack[0], 0);
    chk("rst_dout", dout[0], 0);
    chk("rst_busy", busy[0], 0);
    ndv = 0;
    for (int i = 0; i < ACC + 2; i++) begin
      cycle();
      ndv += int'(dvalid[0] != 0);
    end
    chk("rst_no_dv", ndv, 0);
    xfer(0, 1, 1'b1, 22'h55, 16'h7E57, 2'b11, lat);
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    xfer(0, 1, 1'b0, 22'h55, 16'h0, 2'b00, lat);
    wait_dv(0, 1, td);
    chk("rst_wr_kept", dout[0][31:16], 16'h7E57);

    xfer(0, 0, 1'b1, 22'h400, 16'h5A5A, 2'b11, lat);
    xfer(0, 0, 1'b0, 22'h000, 16'h0, 2'b00, lat);
    wait_dv(0, 0, td);
    chk("alias", dout[0][15:0], 16'h5A5A);

    for (int i = 0; i < 2500; i++) begin
      cycle();
      rst = ($urandom_range(0, 399) == 0);
      for (int g = 0; g < 2; g++) begin
        for (int c = 0; c < 3; c++) begin
          if (req[g][c]) begin
            if (ack[g][c]) begin
              if ($urandom_range(0, 1) == 1) new_req(g, c);
              else req[g][c] = 1'b0;
            end else if ($urandom_range(0, 39) == 0) begin
              req[g][c] = 1'b0;
            end
          end else if ($urandom_range(0, 2) == 0) begin
            new_req(g, c);
          end
        end
      end
    end
    rst = 1'b0;
    req[0] = '0;
    req[1] = '0;
    repeat (20) cycle();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end
endmodule
